// File: rtl/spm_prog_loader_pkg.sv
// Shared types and constants for the SPM program loader: FSM states,
// RISC SPM opcode values, frame constants and error codes.
package spm_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_BASE,
    ST_HDR_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // A LEN byte of zero stands for a full 256-byte image.
  localparam logic [8:0] LEN_ZERO_BYTES = 9'd256;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CHECKSUM = 3'd1;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd2;
  localparam logic [2:0] ERR_TRUNC    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

endpackage

// File: rtl/spm_prog_loader_if.sv
// Byte-stream handshake plus SPM memory write port of the program loader.
interface spm_prog_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/spm_op_class.sv
// Combinational RISC SPM opcode classifier; shared with the disassembly monitor.
module spm_op_class
  import spm_prog_loader_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output logic       has_operand
);

  always_comb begin
    legal       = 1'b0;
    has_operand = 1'b0;
    case (opcode)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_HLT: legal = 1'b1;
      OP_RD, OP_WR, OP_BR, OP_BRZ: begin
        legal       = 1'b1;
        has_operand = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spm_prog_loader.sv
// Frames a BASE/LEN/image/CSUM byte stream into SPM memory, checking opcodes and
// checksum, and holds the CPU in reset until a clean image has been written.
module spm_prog_loader
  import spm_prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  spm_prog_loader_if.slave   bus,
  output logic               cpu_rst_n,
  output logic               busy,
  output logic               done,
  output logic [2:0]         err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              accept_p0;
  logic              op_legal, op_has_operand;
  logic              expect_op, bad_op;
  logic [CNT_W-1:0]  idle_cnt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_ptr;
  logic [8:0]        remain;
  logic [7:0]        sum;
  logic [2:0]        end_code_p0;

  function automatic logic [2:0] end_code(input logic operand_pend, input logic bad,
                                          input logic [7:0] s, input logic [7:0] csum);
    if (operand_pend)  return ERR_TRUNC;
    else if (bad)      return ERR_ILLEGAL;
    else if (s != csum) return ERR_CHECKSUM;
    else               return ERR_NONE;
  endfunction

  spm_op_class u_op_class (
    .opcode      (bus.in_data[7:4]),
    .legal       (op_legal),
    .has_operand (op_has_operand)
  );

  assign busy         = (state == ST_HDR_BASE) || (state == ST_HDR_LEN) ||
                        (state == ST_DATA) || (state == ST_CSUM);
  assign bus.in_ready = busy;
  assign accept_p0    = bus.in_valid && busy;
  assign done         = (state == ST_DONE);
  assign cpu_rst_n    = (state == ST_DONE);
  assign timeout_hit  = busy && !accept_p0 && (idle_cnt == CNT_W'(TIMEOUT - 1));
  assign end_code_p0  = end_code(!expect_op, bad_op, sum, bus.in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (load_start) state_nxt = ST_HDR_BASE;
      ST_HDR_BASE: if (accept_p0) state_nxt = ST_HDR_LEN;
      ST_HDR_LEN:  if (accept_p0) state_nxt = ST_DATA;
      ST_DATA:     if (accept_p0 && remain == 9'd1) state_nxt = ST_CSUM;
      ST_CSUM:     if (accept_p0) state_nxt = (end_code_p0 == ERR_NONE) ? ST_DONE : ST_ERR;
      default:     state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) state_nxt = ST_ERR;
  end

  // stage p0 -> p1: accepted image byte becomes a one-cycle memory write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt        <= '0;
      expect_op       <= 1'b0;
      bad_op          <= 1'b0;
      err_code        <= ERR_NONE;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.mem_wr_en <= accept_p0 && (state == ST_DATA);
      if (accept_p0 && state == ST_DATA) begin
        bus.mem_addr    <= addr_ptr;
        bus.mem_wr_data <= bus.in_data;
      end
      if (!busy || accept_p0) idle_cnt <= '0;
      else                    idle_cnt <= idle_cnt + CNT_W'(1);
      if (load_start && !busy) err_code <= ERR_NONE;
      if (accept_p0 && state == ST_HDR_LEN) begin
        expect_op <= 1'b1;
        bad_op    <= 1'b0;
      end
      // Operand bytes are raw addresses and skip decode.
      if (accept_p0 && state == ST_DATA) begin
        if (expect_op) begin
          if (!op_legal) bad_op <= 1'b1;
          expect_op <= !op_has_operand;
        end else begin
          expect_op <= 1'b1;
        end
      end
      if (accept_p0 && state == ST_CSUM) err_code <= end_code_p0;
      if (timeout_hit) err_code <= ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      case (state)
        ST_HDR_BASE: addr_ptr <= ADDR_W'(bus.in_data);
        ST_HDR_LEN: begin
          remain <= (bus.in_data == 8'd0) ? LEN_ZERO_BYTES : {1'b0, bus.in_data};
          sum    <= 8'd0;
        end
        ST_DATA: begin
          addr_ptr <= addr_ptr + ADDR_W'(1);
          remain   <= remain - 9'd1;
          sum      <= sum + bus.in_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_prog_loader.sv
// Directed bench for spm_prog_loader: framed loads, error codes, wrap, timeout, reset.
module tb_spm_prog_loader;
  import spm_prog_loader_pkg::*;

  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       cpu_rst_n, busy, done;
  logic [2:0] err_code;

  spm_prog_loader_if #(.ADDR_W(8)) bus ();

  spm_prog_loader #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus.slave),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         acc_cnt = 0;
  logic [7:0] img[0:255];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wr_data);
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    tick(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      got = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!got) check("ready_wait", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] base, input int len, input logic [7:0] csum,
                            input int gap);
    start_load();
    send_byte(base, 0);
    send_byte(len[7:0], gap);
    for (int k = 0; k < len; k++) send_byte(img[k], gap * (k % 3));
    send_byte(csum, gap);
  endtask

  task automatic check_writes(input int start, input logic [7:0] base, input int len);
    check("wr_cnt", wr_addr_q.size() - start, len);
    for (int k = 0; k < len && start + k < wr_addr_q.size(); k++) begin
      check("wr_addr", wr_addr_q[start + k], 32'((base + k) & 8'hFF));
      check("wr_data", wr_data_q[start + k], img[k]);
    end
  endtask

  task automatic check_end(input logic exp_done, input logic [2:0] exp_err);
    check("done", done, exp_done);
    check("cpu_rst_n", cpu_rst_n, exp_done);
    check("err_code", err_code, exp_err);
    check("busy", busy, 0);
  endtask

  int start, acc0;

  initial begin
    rst = 1'b1; load_start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    tick(2);
    check("rst_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wr_data, 0);
    check("rst_cpu", cpu_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    rst = 1'b0;
    tick(1);

    // 1: clean image ADD / RD 0x80
    img[0] = 8'h11; img[1] = 8'h50; img[2] = 8'h80;
    start = wr_addr_q.size();
    send_frame(8'h10, 3, 8'hE1, 0);
    check_writes(start, 8'h10, 3);
    check_end(1, ERR_NONE);
    tick(1);
    check_end(1, ERR_NONE);

    // load_start from DONE clears done and drops cpu_rst_n next cycle
    start_load();
    check("restart_done", done, 0);
    check("restart_cpu", cpu_rst_n, 0);
    check("restart_busy", busy, 1);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);

    // 2: same image, checksum off by one
    start = wr_addr_q.size();
    send_frame(8'h10, 3, 8'hE2, 0);
    check_writes(start, 8'h10, 3);
    check_end(0, ERR_CHECKSUM);

    // 3a: unused opcode 0xA at an instruction boundary
    img[0] = 8'hA0; img[1] = 8'h00;
    send_frame(8'h00, 2, 8'hA0, 0);
    check_end(0, ERR_ILLEGAL);
    // 3b: 0xA0 as a BR operand is not decoded
    img[0] = 8'h70; img[1] = 8'hA0;
    send_frame(8'h00, 2, 8'h10, 0);
    check_end(1, ERR_NONE);

    // 4: image ends while WR operand still expected
    img[0] = 8'h60;
    send_frame(8'h00, 1, 8'h60, 0);
    check_end(0, ERR_TRUNC);

    // 5: address wrap
    for (int k = 0; k < 4; k++) img[k] = 8'h00;
    start = wr_addr_q.size();
    send_frame(8'hFE, 4, 8'h00, 0);
    check_writes(start, 8'hFE, 4);
    check_end(1, ERR_NONE);

    // 6: stall mid-DATA until timeout
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tick(TMO - 3);
    check("tmo_busy_early", busy, 1);
    check("tmo_err_early", err_code, 0);
    tick(10);
    check_end(0, ERR_TIMEOUT);

    // 7: reset in the middle of DATA
    start_load();
    send_byte(8'h20, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    start = wr_addr_q.size();
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    tick(2);
    rst = 1'b0;
    tick(3);
    bus.in_valid = 1'b0;
    check("rst7_writes", wr_addr_q.size() - start, 0);
    check("rst7_wr_en", bus.mem_wr_en, 0);
    check("rst7_addr", bus.mem_addr, 0);
    check("rst7_wdata", bus.mem_wr_data, 0);
    check("rst7_ready", bus.in_ready, 0);
    check_end(0, ERR_NONE);

    // 8: in_valid toggling with gaps
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h5F; img[3] = 8'h3C;
    img[4] = 8'h40; img[5] = 8'hF0;
    start = wr_addr_q.size();
    acc0  = acc_cnt;
    send_frame(8'h30, 6, 8'h11 + 8'h22 + 8'h5F + 8'h3C + 8'h40 + 8'hF0, 2);
    check_writes(start, 8'h30, 6);
    check("accepted", acc_cnt - acc0, 9);
    check_end(1, ERR_NONE);

    // 9: load_start while busy is ignored
    img[0] = 8'h00; img[1] = 8'h00;
    start = wr_addr_q.size();
    start_load();
    send_byte(8'h40, 0);
    start_load();
    check("ign_busy", busy, 1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_writes(start, 8'h40, 2);
    check_end(1, ERR_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
